// File: rtl/flipper_hit_detector_if.sv
// Purpose: bundles the per-pixel draw requests into the hit detector and
//          its hit reports out to the trajectory and score logic.
// Ports:   master = pixel/draw source side, slave = hit detector side.
interface flipper_hit_detector_if #(
  parameter int HIT_CNT_W = 8
);
  logic [10:0]          pixelX;
  logic [10:0]          pixelY;
  logic                 startOfFrame;
  logic                 ballDrawReq;
  logic                 flipperDrawReq;
  logic                 diagonalFlipperDrawReq;
  logic                 flatHit;
  logic                 diagHit;
  logic [10:0]          hitX;
  logic [10:0]          hitY;
  logic [HIT_CNT_W-1:0] hitCount;
  logic                 armed;

  modport master (
    output pixelX, pixelY, startOfFrame,
    output ballDrawReq, flipperDrawReq, diagonalFlipperDrawReq,
    input  flatHit, diagHit, hitX, hitY, hitCount, armed
  );

  modport slave (
    input  pixelX, pixelY, startOfFrame,
    input  ballDrawReq, flipperDrawReq, diagonalFlipperDrawReq,
    output flatHit, diagHit, hitX, hitY, hitCount, armed
  );
endinterface

// File: rtl/flipper_hit_detector.sv
// Purpose: per-frame ball/flipper overlap detector with first-contact
//          coordinates, saturating hit counter and frame-based cooldown.
// Latency: hit pulse 1 clk after the startOfFrame that closes the frame;
//          no backpressure, the pixel stream is consumed every cycle.
// Ports:   clk, reset (async, active-high), bus (slave modport): pixel
//          scan position, frame pulse and draw requests in; flatHit/diagHit
//          pulses, hitX/hitY, hitCount and armed out.
module flipper_hit_detector #(
  parameter int COOLDOWN_FRAMES = 3,
  parameter int HIT_CNT_W       = 8
) (
  input logic                    clk,
  input logic                    reset,
  flipper_hit_detector_if.slave  bus
);

  localparam int CNT_W = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

  typedef enum logic {
    ARMED    = 1'b0,
    COOLDOWN = 1'b1
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cool_cnt;

  // Frame accumulators
  logic                 seen_f;
  logic                 seen_d;
  logic                 first_valid;
  logic [10:0]          first_x;
  logic [10:0]          first_y;

  // Registered outputs
  logic                 flat_hit;
  logic                 diag_hit;
  logic [10:0]          hit_x;
  logic [10:0]          hit_y;
  logic [HIT_CNT_W-1:0] hit_count;

  logic                 ov_f;
  logic                 ov_d;

  assign ov_f = bus.ballDrawReq & bus.flipperDrawReq;
  assign ov_d = bus.ballDrawReq & bus.diagonalFlipperDrawReq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ARMED;
      cool_cnt    <= '0;
      seen_f      <= 1'b0;
      seen_d      <= 1'b0;
      first_valid <= 1'b0;
      first_x     <= '0;
      first_y     <= '0;
      flat_hit    <= 1'b0;
      diag_hit    <= 1'b0;
      hit_x       <= '0;
      hit_y       <= '0;
      hit_count   <= '0;
    end else begin
      flat_hit <= 1'b0;
      diag_hit <= 1'b0;

      if (bus.startOfFrame) begin
        // Judge the frame that just closed using the old accumulators.
        case (state)
          ARMED: begin
            if (seen_f | seen_d) begin
              // Diagonal wins when both segments were touched.
              diag_hit <= seen_d;
              flat_hit <= ~seen_d;
              hit_x    <= first_x;
              hit_y    <= first_y;
              if (hit_count != {HIT_CNT_W{1'b1}}) begin
                hit_count <= hit_count + HIT_CNT_W'(1);
              end
              if (COOLDOWN_FRAMES > 0) begin
                state    <= COOLDOWN;
                cool_cnt <= CNT_W'(COOLDOWN_FRAMES);
              end
            end
          end
          COOLDOWN: begin
            cool_cnt <= cool_cnt - CNT_W'(1);
            if (cool_cnt == CNT_W'(1)) begin
              state <= ARMED;
            end
          end
          default: state <= ARMED;
        endcase

        // The startOfFrame cycle itself is the first pixel of the new frame.
        seen_f      <= ov_f;
        seen_d      <= ov_d;
        first_valid <= ov_f | ov_d;
        if (ov_f | ov_d) begin
          first_x <= bus.pixelX;
          first_y <= bus.pixelY;
        end
      end else begin
        seen_f <= seen_f | ov_f;
        seen_d <= seen_d | ov_d;
        if (!first_valid && (ov_f | ov_d)) begin
          first_valid <= 1'b1;
          first_x     <= bus.pixelX;
          first_y     <= bus.pixelY;
        end
      end
    end
  end

  assign bus.flatHit  = flat_hit;
  assign bus.diagHit  = diag_hit;
  assign bus.hitX     = hit_x;
  assign bus.hitY     = hit_y;
  assign bus.hitCount = hit_count;
  assign bus.armed    = (state == ARMED);

endmodule

// File: tb/tb_flipper_hit_detector.sv
module tb_flipper_hit_detector;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Shared stimulus driven into both DUT instances
  logic [10:0] px = '0;
  logic [10:0] py = '0;
  logic        sof = 1'b0;
  logic        ball = 1'b0;
  logic        flat = 1'b0;
  logic        diag = 1'b0;

  // A: default parameters (cooldown 3, 8-bit counter)
  flipper_hit_detector_if #(.HIT_CNT_W(8)) ifa ();
  // B: no cooldown, 2-bit counter
  flipper_hit_detector_if #(.HIT_CNT_W(2)) ifb ();

  assign ifa.pixelX = px;
  assign ifa.pixelY = py;
  assign ifa.startOfFrame = sof;
  assign ifa.ballDrawReq = ball;
  assign ifa.flipperDrawReq = flat;
  assign ifa.diagonalFlipperDrawReq = diag;
  assign ifb.pixelX = px;
  assign ifb.pixelY = py;
  assign ifb.startOfFrame = sof;
  assign ifb.ballDrawReq = ball;
  assign ifb.flipperDrawReq = flat;
  assign ifb.diagonalFlipperDrawReq = diag;

  flipper_hit_detector #(.COOLDOWN_FRAMES(3), .HIT_CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave)
  );
  flipper_hit_detector #(.COOLDOWN_FRAMES(0), .HIT_CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave)
  );

  typedef struct {
    logic        sof, b, f, d;
    logic [10:0] x, y;
    logic        ef, ed;
    logic [10:0] ex, ey;
    logic [7:0]  ec;
    logic        ea;
  } vec_t;

  vec_t tbl[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic vec_t mk(logic s, logic b, logic f, logic d,
                              int x, int y, logic ef, logic ed,
                              int ex, int ey, int ec, logic ea);
    vec_t v;
    v.sof = s; v.b = b; v.f = f; v.d = d;
    v.x = 11'(x); v.y = 11'(y);
    v.ef = ef; v.ed = ed;
    v.ex = 11'(ex); v.ey = 11'(ey);
    v.ec = 8'(ec); v.ea = ea;
    return v;
  endfunction

  // {flatHit, diagHit, hitX, hitY, hitCount(8), armed}
  function automatic logic [32:0] pack_a();
    return {ifa.flatHit, ifa.diagHit, ifa.hitX, ifa.hitY, ifa.hitCount, ifa.armed};
  endfunction
  function automatic logic [32:0] pack_b();
    return {ifb.flatHit, ifb.diagHit, ifb.hitX, ifb.hitY, 6'd0, ifb.hitCount, ifb.armed};
  endfunction
  function automatic logic [32:0] pack_exp(logic ef, logic ed, int ex, int ey,
                                           int ec, logic ea);
    return {ef, ed, 11'(ex), 11'(ey), 8'(ec), ea};
  endfunction

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got flat=%0b diag=%0b x=%0d y=%0d cnt=%0d armed=%0b, want flat=%0b diag=%0b x=%0d y=%0d cnt=%0d armed=%0b",
               name, act[32], act[31], act[30:20], act[19:9], act[8:1], act[0],
               exp[32], exp[31], exp[30:20], exp[19:9], exp[8:1], exp[0]);
    end
  endtask

  // Drive one pixel cycle at the falling edge, sample 1 time unit after the rising edge.
  task automatic apply(input logic s, input logic b, input logic f, input logic d,
                       input int x, input int y);
    @(negedge clk);
    sof = s; ball = b; flat = f; diag = d;
    px = 11'(x); py = 11'(y);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Flat hit at first overlap (300,390), then cooldown of 3 frames
    tbl.push_back(mk(1,0,0,0,   0,  0, 0,0,  0,  0,0,1));
    tbl.push_back(mk(0,1,1,0, 300,390, 0,0,  0,  0,0,1));
    tbl.push_back(mk(0,1,1,0, 301,390, 0,0,  0,  0,0,1));
    tbl.push_back(mk(0,0,0,0,   0,  0, 0,0,  0,  0,0,1));
    tbl.push_back(mk(1,0,0,0,   0,  0, 1,0,300,390,1,0));
    tbl.push_back(mk(0,0,0,0,   0,  0, 0,0,300,390,1,0));
    tbl.push_back(mk(1,0,0,0,   0,  0, 0,0,300,390,1,0));
    tbl.push_back(mk(1,0,0,0,   0,  0, 0,0,300,390,1,0));
    tbl.push_back(mk(1,0,0,0,   0,  0, 0,0,300,390,1,1));
    // Flat first at (310,400), diagonal later: diagonal reported, flat coords kept
    tbl.push_back(mk(0,1,1,0, 310,400, 0,0,300,390,1,1));
    tbl.push_back(mk(0,1,0,1, 290,395, 0,0,300,390,1,1));
    tbl.push_back(mk(1,0,0,0,   0,  0, 0,1,310,400,2,0));
    tbl.push_back(mk(0,0,0,0,   0,  0, 0,0,310,400,2,0));
    tbl.push_back(mk(1,0,0,0,   0,  0, 0,0,310,400,2,0));
    tbl.push_back(mk(1,0,0,0,   0,  0, 0,0,310,400,2,0));
    tbl.push_back(mk(1,0,0,0,   0,  0, 0,0,310,400,2,1));
    // Overlap only in the startOfFrame cycle belongs to the next frame
    tbl.push_back(mk(1,1,1,0, 320,392, 0,0,310,400,2,1));
    tbl.push_back(mk(0,0,0,0,   0,  0, 0,0,310,400,2,1));
    tbl.push_back(mk(0,0,0,0,   0,  0, 0,0,310,400,2,1));
    tbl.push_back(mk(1,0,0,0,   0,  0, 1,0,320,392,3,0));
    tbl.push_back(mk(0,0,0,0,   0,  0, 0,0,320,392,3,0));
    tbl.push_back(mk(1,0,0,0,   0,  0, 0,0,320,392,3,0));
    tbl.push_back(mk(1,0,0,0,   0,  0, 0,0,320,392,3,0));
    tbl.push_back(mk(1,0,0,0,   0,  0, 0,0,320,392,3,1));
    // Six consecutive hit frames: reports after frames 1 and 5 only
    tbl.push_back(mk(0,1,1,0, 100,100, 0,0,320,392,3,1));
    tbl.push_back(mk(1,0,0,0,   0,  0, 1,0,100,100,4,0));
    tbl.push_back(mk(0,1,1,0, 101,101, 0,0,100,100,4,0));
    tbl.push_back(mk(1,0,0,0,   0,  0, 0,0,100,100,4,0));
    tbl.push_back(mk(0,1,1,0, 102,102, 0,0,100,100,4,0));
    tbl.push_back(mk(1,0,0,0,   0,  0, 0,0,100,100,4,0));
    tbl.push_back(mk(0,1,1,0, 103,103, 0,0,100,100,4,0));
    tbl.push_back(mk(1,0,0,0,   0,  0, 0,0,100,100,4,1));
    tbl.push_back(mk(0,1,1,1, 104,104, 0,0,100,100,4,1));
    tbl.push_back(mk(1,0,0,0,   0,  0, 0,1,104,104,5,0));
    tbl.push_back(mk(0,1,1,0, 105,105, 0,0,104,104,5,0));
    tbl.push_back(mk(1,0,0,0,   0,  0, 0,0,104,104,5,0));

    // Reset values while reset is held
    repeat (2) @(negedge clk);
    #1;
    check("reset_a", pack_a(), pack_exp(0,0,0,0,0,1));
    check("reset_b", pack_b(), pack_exp(0,0,0,0,0,1));
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      apply(tbl[i].sof, tbl[i].b, tbl[i].f, tbl[i].d, tbl[i].x, tbl[i].y);
      check($sformatf("vec%0d", i), pack_a(),
            pack_exp(tbl[i].ef, tbl[i].ed, tbl[i].ex, tbl[i].ey, tbl[i].ec, tbl[i].ea));
    end

    // Reset mid-cooldown (counter=2): immediate return to reset values
    @(negedge clk);
    sof = 0; ball = 0; flat = 0; diag = 0;
    reset = 1'b1;
    #1;
    check("async_reset_a", pack_a(), pack_exp(0,0,0,0,0,1));
    @(negedge clk);
    reset = 1'b0;
    apply(0,0,0,0,0,0);
    check("post_reset_a", pack_a(), pack_exp(0,0,0,0,0,1));
    apply(0,1,1,0,50,60);
    check("post_reset_ov_a", pack_a(), pack_exp(0,0,0,0,0,1));
    apply(1,0,0,0,0,0);
    check("post_reset_hit_a", pack_a(), pack_exp(1,0,50,60,1,0));
    check("post_reset_hit_b", pack_b(), pack_exp(1,0,50,60,1,1));

    // B: no cooldown, 2-bit counter saturates at 3
    for (int k = 1; k <= 4; k++) begin
      apply(0,1,1,0,60+k,70);
      check($sformatf("b_gap%0d", k), pack_b(),
            pack_exp(0,0,(k == 1) ? 50 : 59+k,(k == 1) ? 60 : 70,(k < 3) ? k : 3,1));
      apply(1,0,0,0,0,0);
      check($sformatf("b_hit%0d", k), pack_b(),
            pack_exp(1,0,60+k,70,(k + 1 < 3) ? k + 1 : 3,1));
    end
    apply(0,0,0,0,0,0);
    check("b_tail", pack_b(), pack_exp(0,0,64,70,3,1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
